// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive packer: FSM encoding, parameter defaults
// and the byte-count width.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2,
    ST_PUSH = 2'd3
  } state_t;

  localparam int FIFO_DEPTH_DEF = 4;
  localparam int TMO_CYCLES_DEF = 4096;
  localparam int CNT_W          = 3;

endpackage

// File: rtl/uart_word_fifo.sv
// First-word fall-through FIFO. A write into an empty FIFO is visible on rd_data
// in the same cycle, and a simultaneous read consumes it without storing it.
module uart_word_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty, full, rd_fire, wr_fire, store, pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    rd_valid = !empty || wr_en;
    rd_fire  = rd_en && rd_valid;
    wr_ready = !full || rd_en;
    wr_fire  = wr_en && wr_ready;
    // On an empty FIFO a concurrent read takes the write data straight through.
    store    = wr_fire && !(empty && rd_fire);
    pop      = rd_fire && !empty;
    rd_data  = !empty ? mem_q[rd_ptr_q] : (wr_en ? wr_data : '0);

    wr_ptr_d = store ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({store, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_packer.sv
// Packs bytes from a UART receive core into 1- or 4-byte words with a partial-word
// idle flush, and queues them in a small word FIFO.
//   state   | meaning
//   IDLE    | wait for a byte, or flush a partial word (burst dropped / idle timeout)
//   ACK     | pop pulse to the core, capture byte into lane cnt
//   HOLD    | ignore u_dv for one cycle while the core clears it
//   PUSH    | write the word into the FIFO, stall while it is full
module uart_rx_packer
  import uart_pkg::*;
#(
  parameter int TMO_CYCLES = TMO_CYCLES_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic [7:0]       u_q,
  input  logic             u_dv,
  input  logic             u_fe,
  input  logic             u_ove,
  output logic             u_rd,
  input  logic             burst,
  output logic [31:0]      w_q,
  output logic [CNT_W-1:0] w_nbytes,
  output logic             w_fe,
  output logic             w_valid,
  input  logic             w_rd,
  output logic             ovf,
  input  logic             clr_ovf
);

  localparam int TW = $clog2(TMO_CYCLES + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      word_q, word_d;
  logic             fe_q, fe_d;
  logic [TW-1:0]    idle_q, idle_d;
  logic             ovf_q, ovf_d;
  logic             u_rd_q, u_rd_d;
  logic             push_ready, push_fire, complete;
  logic [35:0]      head;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    fe_d      = fe_q;
    idle_d    = idle_q;
    push_fire = (state_q == ST_PUSH) && push_ready;
    complete  = burst ? (cnt_q == CNT_W'(4)) : (cnt_q == CNT_W'(1));

    case (state_q)
      ST_IDLE: begin
        if (cnt_q != '0 && (!burst || idle_q == TW'(TMO_CYCLES))) begin
          state_d = ST_PUSH;
          idle_d  = '0;
        end else begin
          if (u_dv) state_d = ST_ACK;
          if (cnt_q != '0) idle_d = idle_q + TW'(1);
        end
      end
      ST_ACK: begin
        word_d[{cnt_q[1:0], 3'b000} +: 8] = u_q;
        fe_d    = fe_q | u_fe;
        cnt_d   = cnt_q + CNT_W'(1);
        idle_d  = '0;
        state_d = ST_HOLD;
      end
      ST_HOLD: state_d = complete ? ST_PUSH : ST_IDLE;
      ST_PUSH: begin
        if (push_fire) begin
          cnt_d   = '0;
          word_d  = '0;
          fe_d    = 1'b0;
          idle_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Set is applied last so a coinciding clear loses.
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (state_q == ST_ACK && u_ove) ovf_d = 1'b1;

    u_rd_d = (state_d == ST_ACK);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      fe_q    <= 1'b0;
      idle_q  <= '0;
      ovf_q   <= 1'b0;
      u_rd_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      fe_q    <= fe_d;
      idle_q  <= idle_d;
      ovf_q   <= ovf_d;
      u_rd_q  <= u_rd_d;
    end
  end

  uart_word_fifo #(
    .WIDTH(36),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetb  (resetb),
    .wr_en   (state_q == ST_PUSH),
    .wr_data ({fe_q, cnt_q, word_q}),
    .wr_ready(push_ready),
    .rd_en   (w_rd),
    .rd_data (head),
    .rd_valid(w_valid)
  );

  assign u_rd     = u_rd_q;
  assign ovf      = ovf_q;
  assign w_fe     = head[35];
  assign w_nbytes = head[34:32];
  assign w_q      = head[31:0];

endmodule

// File: doc/uart_rx_packer.md
UART_RX_PACKER -- requirements
Module: uart_rx_packer

Interface
REQ-001 Parameter TMO_CYCLES, default 4096, sets the number of idle clk cycles before a partial word is flushed.
REQ-002 Parameter FIFO_DEPTH, default 4, sets the word FIFO depth; it SHALL be a power of 2 and at least 2.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 resetb  in  1  asynchronous, active-low reset.
REQ-005 u_q  in  8  received byte from the UART core.
REQ-006 u_dv  in  1  core byte-valid flag.
REQ-007 u_fe  in  1  core framing-error flag for u_q.
REQ-008 u_ove  in  1  core overrun flag.
REQ-009 u_rd  out  1  one-cycle pop pulse to the core.
REQ-010 burst  in  1  1 = pack 4 bytes per word; 0 = one byte per word.
REQ-011 w_q  out  32  FIFO head word; byte k occupies bits [8k+7:8k], and k=0 is the first byte received.
REQ-012 w_nbytes  out  3  valid byte count of the head word, range 1..4.
REQ-013 w_fe  out  1  OR of u_fe over all bytes of the head word.
REQ-014 w_valid  out  1  FIFO not empty.
REQ-015 w_rd  in  1  pops the head word.
REQ-016 ovf  out  1  sticky overrun flag.
REQ-017 clr_ovf  in  1  clears ovf.

Function
REQ-018 FSM states: IDLE, ACK, HOLD, PUSH.
- IDLE: u_dv=1 and staging register free -> ACK.
- ACK: u_rd=1 for exactly one cycle; capture u_q into lane cnt; increment cnt; -> HOLD.
- HOLD: u_dv is ignored for one cycle while the core clears it; -> PUSH if the word is complete, else -> IDLE.
REQ-019 A word is complete when cnt=4 with burst=1, or when cnt=1 with burst=0.
REQ-020 PUSH writes {word, cnt, fe_acc} into the FIFO when it is not full, then clears cnt, the word and fe_acc, and goes to IDLE.
- When the FIFO is full, the FSM stays in PUSH and u_rd stays 0 (backpressure).
REQ-021 Latency: u_dv rising in cycle N gives u_rd in cycle N+1.
- A completing byte gives w_valid=1 in cycle N+3 when the FIFO was empty.
REQ-022 Unused byte lanes of a pushed word SHALL be zero.
REQ-023 Timeout: in IDLE with 1<=cnt<=3, an idle counter increments every cycle and resets on every ACK.
- When it reaches TMO_CYCLES, the FSM goes to PUSH with the partial word and w_nbytes=cnt.
REQ-024 When burst falls to 0 with cnt>0, the partial word is flushed via PUSH at the next IDLE cycle.
- When burst rises, the change takes effect from the next byte.
REQ-025 The FIFO is first-word fall-through: w_q, w_nbytes and w_fe are valid whenever w_valid=1.
REQ-026 w_rd with w_valid=0 SHALL be ignored.
REQ-027 Simultaneous push and pop on a full FIFO SHALL succeed and leave the occupancy unchanged.
REQ-028 u_ove=1 sampled in ACK sets ovf.
- ovf is cleared by clr_ovf.
- When set and clear coincide, set wins.
REQ-029 fe_acc ORs u_fe at each ACK.

Reset
REQ-030 resetb=0 asynchronously forces: state IDLE, cnt=0, idle counter=0, FIFO empty, u_rd=0, w_valid=0, w_q=0, w_nbytes=0, w_fe=0, ovf=0.
REQ-031 Reset asserted mid-word discards the partial word.
- The next byte after reset release goes to lane 0.

Structure
REQ-032 Shared package uart_pkg SHALL hold:
- the FSM state encoding;
- the FIFO_DEPTH and TMO_CYCLES defaults;
- the 3-bit byte-count width constant.
REQ-033 One sub-module, uart_word_fifo (width 36, depth FIFO_DEPTH, same clk/resetb), SHALL implement the word FIFO.

Verification
REQ-034 burst=1; bytes 68,6F,6C,61 -> exactly one word: w_q=616C6F68, w_nbytes=4, w_fe=0, and exactly 4 u_rd pulses.
REQ-035 burst=0; byte 41 -> w_q=00000041, w_nbytes=1; then byte 42 -> a second word 00000042.
REQ-036 burst=1; bytes 41,42 then idle TMO_CYCLES -> w_q=00004241, w_nbytes=2; then byte 5A -> lane 0.
REQ-037 burst=1; 5 full words, no w_rd -> FIFO holds 4 words and u_rd stays 0 on the 5th; w_rd once -> the 5th word enters the FIFO; order is preserved.
REQ-038 u_fe=1 on the 3rd byte and u_ove=1 on the 4th -> w_fe=1, ovf=1; clr_ovf -> ovf=0.
REQ-039 resetb pulse after 2 bytes -> all outputs 0; a following 4-byte burst -> one correct word.
